// File: rtl/uart_tx_engine_pkg.sv
// ============================================================================
// uart_tx_engine_pkg : shared UART frame encodings, clamp limits, TX states
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_tx_engine_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   localparam logic [1:0] STOP_1   = 2'b00;
   localparam logic [1:0] STOP_1P5 = 2'b01;
   localparam logic [1:0] STOP_2   = 2'b10;

   localparam logic [3:0] DATA_BITS_MIN = 4'd5;
   localparam logic [3:0] DATA_BITS_MAX = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } tx_state_t;

   function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
      if (bits < DATA_BITS_MIN) begin
         return DATA_BITS_MIN;
      end
      if (bits > DATA_BITS_MAX) begin
         return DATA_BITS_MAX;
      end
      return bits;
   endfunction

   // 2'b11 aliases to the 2-stop and no-parity encodings respectively
   function automatic logic [1:0] norm_stop(input logic [1:0] sel);
      case (sel)
         STOP_1:   return STOP_1;
         STOP_1P5: return STOP_1P5;
         default:  return STOP_2;
      endcase
   endfunction

   function automatic logic [1:0] norm_parity(input logic [1:0] sel);
      case (sel)
         PAR_ODD:  return PAR_ODD;
         PAR_EVEN: return PAR_EVEN;
         default:  return PAR_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_engine_baud_cnt.sv
// ============================================================================
// uart_baud_cnt : reloadable down-counter with terminal-count tick
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_cnt #(
   parameter int WIDTH = 13
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick
);

   logic [WIDTH-1:0] r_cnt;

   // load wins over counting so a segment can restart on its own tick
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign count = r_cnt;
   assign tick  = en && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================================
// uart_tx_engine : UART serialiser, FIFO pop -> start/data/parity/stop on txd_o
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_engine
   import uart_tx_engine_pkg::*;
#(
   parameter int DLY = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        low_power,
   input  logic [3:0]  data_bits,
   input  logic [1:0]  stop_bits,
   input  logic [1:0]  parity_mode,
   input  logic [11:0] baudrate_cfg,
   input  logic        tx_fifo_empty,
   output logic        tx_fifo_rd_en,
   input  logic [7:0]  tx_fifo_rd_data,
   output logic        txd_o,
   output logic        tx_busy,
   output logic        tx_done
);

   tx_state_t   r_state;
   logic [7:0]  r_shift;
   logic [2:0]  r_last_idx;
   logic [2:0]  r_bit_cnt;
   logic [1:0]  r_stop;
   logic [1:0]  r_par_mode;
   logic [11:0] r_baud;
   logic        r_par_bit;
   logic        r_stop_seg;
   logic        r_txd;
   logic        r_rd_en;
   logic        r_busy;
   logic        r_done;

   logic [3:0]  w_nbits;
   logic [7:0]  w_mask;
   logic        w_par_raw;
   logic        w_par_bit;
   logic [12:0] w_p_m1;
   logic [12:0] w_half;
   logic [12:0] w_b_len_m1;
   logic        w_has_b;
   logic        w_par_en;
   logic        w_last_bit;
   logic        w_pop_ok;
   logic        w_en;
   logic        w_load;
   logic [12:0] w_load_val;
   logic [12:0] w_count;
   logic        w_tick;
   logic        w_entering_stop;
   logic        w_final_seg;
   logic        w_done_next;

   // DLY only annotates delay-modelled siblings; it has no effect here
   generate
      if (DLY < 0) begin : g_dly_unused
      end
   endgenerate

   assign w_nbits   = clamp_data_bits(data_bits);
   assign w_mask    = 8'hFF >> (4'd8 - w_nbits);
   assign w_par_raw = ^(tx_fifo_rd_data & w_mask);
   assign w_par_bit = (parity_mode == PAR_ODD) ? ~w_par_raw : w_par_raw;

   // Stop time is segment A (P) plus optional segment B (P or P>>1)
   assign w_p_m1     = {1'b0, r_baud};
   assign w_half     = (w_p_m1 + 13'd1) >> 1;
   assign w_has_b    = (r_stop == STOP_2) || ((r_stop == STOP_1P5) && (w_half != '0));
   assign w_b_len_m1 = (r_stop == STOP_2) ? w_p_m1 : (w_half - 13'd1);

   assign w_par_en   = (r_par_mode == PAR_ODD) || (r_par_mode == PAR_EVEN);
   assign w_last_bit = (r_bit_cnt == r_last_idx);
   assign w_pop_ok   = !tx_fifo_empty && !low_power;

   assign w_en   = (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
   assign w_load = (r_state == ST_FETCH)
                || (w_tick && (r_state inside {ST_START, ST_DATA, ST_PARITY}))
                || (w_tick && (r_state == ST_STOP) && !r_stop_seg && w_has_b);
   assign w_load_val = (r_state == ST_FETCH) ? {1'b0, baudrate_cfg} :
                       (r_state == ST_STOP)  ? w_b_len_m1 : w_p_m1;

   uart_baud_cnt #(
      .WIDTH (13)
   ) u_baud_cnt (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .en       (w_en),
      .load     (w_load),
      .load_val (w_load_val),
      .count    (w_count),
      .tick     (w_tick)
   );

   // tx_done is registered, so predict the cycle before the final stop tick
   assign w_entering_stop = w_tick && (((r_state == ST_DATA) && w_last_bit && !w_par_en)
                                       || (r_state == ST_PARITY));
   assign w_final_seg     = (r_state == ST_STOP) && (r_stop_seg || !w_has_b);
   assign w_done_next     = (w_final_seg && !w_tick && (w_count == 13'd1))
                         || (w_entering_stop && (r_baud == '0) && !w_has_b)
                         || ((r_state == ST_STOP) && w_tick && !r_stop_seg && w_has_b
                             && (w_b_len_m1 == '0));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_last_idx <= '0;
         r_bit_cnt  <= '0;
         r_stop     <= '0;
         r_par_mode <= '0;
         r_baud     <= '0;
         r_par_bit  <= 1'b0;
         r_stop_seg <= 1'b0;
         r_txd      <= 1'b1;
         r_rd_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_done_next;
         case (r_state)
            ST_IDLE: begin
               r_txd  <= 1'b1;
               r_busy <= 1'b0;
               if (r_rd_en) begin
                  r_rd_en <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_FETCH;
               end else begin
                  r_rd_en <= w_pop_ok;
               end
            end
            ST_FETCH: begin
               r_shift    <= tx_fifo_rd_data;
               r_last_idx <= 3'(w_nbits - 4'd1);
               r_stop     <= norm_stop(stop_bits);
               r_par_mode <= norm_parity(parity_mode);
               r_baud     <= baudrate_cfg;
               r_par_bit  <= w_par_bit;
               r_bit_cnt  <= '0;
               r_stop_seg <= 1'b0;
               r_txd      <= 1'b0;
               r_state    <= ST_START;
            end
            ST_START: begin
               if (w_tick) begin
                  r_txd   <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (!w_last_bit) begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_txd     <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                  end else if (w_par_en) begin
                     r_txd   <= r_par_bit;
                     r_state <= ST_PARITY;
                  end else begin
                     r_txd   <= 1'b1;
                     r_state <= ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_txd   <= 1'b1;
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  if (!r_stop_seg && w_has_b) begin
                     r_stop_seg <= 1'b1;
                  end else begin
                     r_busy  <= 1'b0;
                     r_rd_en <= w_pop_ok;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_rd_en <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_fifo_rd_en = r_rd_en;
   assign txd_o         = r_txd;
   assign tx_busy       = r_busy;
   assign tx_done       = r_done;

endmodule

`default_nettype wire

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
UART serial transmitter. Consumes the frame configuration produced by the UART status/control register block (low_power, data_bits, stop_bits, parity_mode, baudrate_cfg). Pops bytes from the TX FIFO read port and serialises them on txd_o as start / data (LSB first) / optional parity / stop. Sits between the TX FIFO and the pad, and reports busy/done back to the status logic.

Parameters:
DLY, 1, simulation delay applied on every register assignment; no functional effect.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
low_power  input  1  1 = do not start new frames
data_bits  input  4  data bits per frame; 5..8 used directly, <5 clamps to 5, >8 clamps to 8
stop_bits  input  2  00 = 1 stop bit, 01 = 1.5 stop bits, 10/11 = 2 stop bits
parity_mode  input  2  00 = none, 01 = odd, 10 = even, 11 = none
baudrate_cfg  input  12  bit period minus 1, in clk_i cycles
tx_fifo_empty  input  1  TX FIFO empty flag
tx_fifo_rd_en  output  1  one-cycle pop strobe
tx_fifo_rd_data  input  8  FIFO data, valid the cycle after tx_fifo_rd_en
txd_o  output  1  serial line, idle high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (asynchronous, mid-frame included): state IDLE, txd_o=1, tx_fifo_rd_en=0, tx_busy=0, tx_done=0, all counters 0. A byte already fetched is discarded.
- All outputs are registered.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: if !tx_fifo_empty && !low_power, drive tx_fifo_rd_en=1 for exactly one cycle and go to FETCH.
- FETCH, one cycle:
  - capture tx_fifo_rd_data into the shift register;
  - latch data_bits (clamped), stop_bits, parity_mode and baudrate_cfg into shadow registers;
  - compute parity over the latched data bits only: odd => bit = ~^data, even => bit = ^data;
  - tx_busy rises;
  - go to START.
- Bit period is P = baudrate_cfg+1 cycles (shadow value). baudrate_cfg=0 gives 1 cycle per bit.
- Configuration changes mid-frame have no effect until the next FETCH.
- START: txd_o=0 for P cycles.
- DATA: shift out LSB first, P cycles per bit, N bits (N = clamped data_bits).
- After DATA: go to PARITY if parity is enabled, otherwise STOP.
- PARITY: txd_o = parity bit for P cycles.
- STOP: txd_o=1 for the stop length:
  - 1 stop: P cycles;
  - 1.5 stop: P + (P>>1) cycles;
  - 2 stop: 2P cycles.
- Last STOP cycle: tx_done=1 for that cycle only; next state IDLE; tx_busy falls with the IDLE entry.
- Frame timing, with pop in cycle T:
  - capture at T+1;
  - txd_o falls at T+2;
  - total frame length from T+2 = (1+N+par)*P + stop length.
- Back-to-back frames: minimum 2 idle-high cycles (IDLE, FETCH) between the end of stop and the next start bit. This is legal extended stop.
- low_power asserted mid-frame: the current frame completes; no further pops occur.
- low_power deasserted with data pending: pop on the next IDLE cycle.
- tx_fifo_rd_en is never asserted while tx_fifo_empty=1 and never outside IDLE.
- Counter widths:
  - baud counter is 13 bits, so the 2P / 1.5P stop counts are covered by looping P per stop bit plus a half-period segment;
  - bit counter is 3 bits (0..7).

Decomposition:
- Shared define/package file uart_defines:
  - parity encodings (PAR_NONE, PAR_ODD, PAR_EVEN);
  - stop encodings (STOP_1, STOP_1P5, STOP_2);
  - data-bit clamp limits (5, 8);
  - state encoding for uart_tx_engine.
- One sub-module: uart_baud_cnt, a reloadable down-counter with load value and one-cycle terminal-count tick. It is reusable by the future receiver.

Test Plan:
- 8N1, baudrate_cfg=3, FIFO holds 0xA5 -> one rd_en pulse. txd_o from T+2 is 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. tx_done pulses at cycle T+41. Exactly one pop.
- 7E1, baudrate_cfg=3, data 0xA5 -> 7 data bits 1,0,1,0,0,1,0, then parity 1. Odd mode with the same data gives parity 0.
- 8N1.5, baudrate_cfg=3 -> stop high for 6 cycles. 8N2 gives 8 cycles. data_bits=4'd12 behaves as 8 bits; data_bits=4'd2 behaves as 5 bits.
- FIFO holds 3 bytes, 8N1, baudrate_cfg=0 -> three frames, each 10 cycles, separated by exactly 2 idle-high cycles. Three tx_done pulses; tx_fifo_rd_en never asserted while empty.
- baudrate_cfg changed 7->3 and low_power set during the DATA state -> current frame keeps 8-cycle bits and completes. No new pop until low_power is cleared, after which the next frame uses 4-cycle bits.
- rst_n_i asserted mid-DATA -> txd_o=1, tx_busy=0, tx_done=0 immediately. After release the next FIFO byte transmits normally.
